// File: rtl/reg_bank_dp.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : reg_bank_dp                                                |
// | Description : Register bank with one bit-masked write port, two          |
// |               independent registered read ports and a clear sequencer    |
// |               that sweeps every entry to CLR_VALUE after reset or on clr.|
// | Option      : REG_BANK_BYPASS_EN - write-first forwarding on same-cycle  |
// |               read/write to the same address (default: read-first).      |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module reg_bank_dp #(
  parameter int                   ADDR_BITS = 4,
  parameter int                   DATA_BITS = 8,
  parameter logic [DATA_BITS-1:0] CLR_VALUE = '0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  input  logic                 wr_en,
  input  logic [ADDR_BITS-1:0] wr_addr,
  input  logic [DATA_BITS-1:0] wr_data,
  input  logic [DATA_BITS-1:0] wr_mask,
  input  logic                 rd_en_a,
  input  logic [ADDR_BITS-1:0] rd_addr_a,
  output logic [DATA_BITS-1:0] rd_data_a,
  output logic                 rd_valid_a,
  input  logic                 rd_en_b,
  input  logic [ADDR_BITS-1:0] rd_addr_b,
  output logic [DATA_BITS-1:0] rd_data_b,
  output logic                 rd_valid_b,
  output logic                 busy
);

  localparam int                   c_DEPTH    = 2 ** ADDR_BITS;
  localparam logic [ADDR_BITS-1:0] c_LAST_PTR = '1;

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_CLEAR = 1'b1
  } state_t;

  state_t                 r_state;
  state_t                 w_state_next;
  logic [ADDR_BITS-1:0]   r_clr_ptr;
  logic [ADDR_BITS-1:0]   w_clr_ptr_next;

  logic [DATA_BITS-1:0]   r_bank [c_DEPTH];

  logic [DATA_BITS-1:0]   r_rd_data_a;
  logic [DATA_BITS-1:0]   r_rd_data_b;
  logic                   r_rd_valid_a;
  logic                   r_rd_valid_b;

  logic                   w_idle;
  logic                   w_wr_accept;
  logic [DATA_BITS-1:0]   w_wr_merged;
  logic [DATA_BITS-1:0]   w_rd_val_a;
  logic [DATA_BITS-1:0]   w_rd_val_b;

  // A clear request in the same cycle wins over a write, so the write is dropped.
  assign w_idle      = (r_state == S_IDLE);
  assign w_wr_accept = w_idle && wr_en && !clr;
  assign w_wr_merged = (r_bank[wr_addr] & ~wr_mask) | (wr_data & wr_mask);

`ifdef REG_BANK_BYPASS_EN
  // Write-first: a read hitting the address being written sees the merged value.
  assign w_rd_val_a = (w_wr_accept && (rd_addr_a == wr_addr)) ? w_wr_merged : r_bank[rd_addr_a];
  assign w_rd_val_b = (w_wr_accept && (rd_addr_b == wr_addr)) ? w_wr_merged : r_bank[rd_addr_b];
`else
  // Read-first: the array read naturally returns the pre-write contents.
  assign w_rd_val_a = r_bank[rd_addr_a];
  assign w_rd_val_b = r_bank[rd_addr_b];
`endif

  // State and sweep pointer register; reset always (re)starts a sweep at entry 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_CLEAR;
      r_clr_ptr <= '0;
    end else begin
      r_state   <= w_state_next;
      r_clr_ptr <= w_clr_ptr_next;
    end
  end

  // Next-state logic; the sweep leaves CLEAR on the last entry so the pointer never wraps.
  always_comb begin
    w_state_next   = r_state;
    w_clr_ptr_next = r_clr_ptr;
    case (r_state)
      S_IDLE: begin
        if (clr) begin
          w_state_next   = S_CLEAR;
          w_clr_ptr_next = '0;
        end
      end
      S_CLEAR: begin
        if (r_clr_ptr == c_LAST_PTR) begin
          w_state_next = S_IDLE;
        end else begin
          w_clr_ptr_next = r_clr_ptr + 1'b1;
        end
      end
      default: begin
        w_state_next   = S_CLEAR;
        w_clr_ptr_next = '0;
      end
    endcase
  end

  // Storage array: sweep writes take precedence; nothing is written on a reset edge.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (r_state == S_CLEAR) begin
        r_bank[r_clr_ptr] <= CLR_VALUE;
      end else if (w_wr_accept) begin
        r_bank[wr_addr] <= w_wr_merged;
      end
    end
  end

  // Port A read register: serviced only in IDLE, data holds when not reading.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_data_a  <= '0;
      r_rd_valid_a <= 1'b0;
    end else if (w_idle && rd_en_a) begin
      r_rd_data_a  <= w_rd_val_a;
      r_rd_valid_a <= 1'b1;
    end else begin
      r_rd_valid_a <= 1'b0;
    end
  end

  // Port B read register: independent copy of port A behaviour.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_data_b  <= '0;
      r_rd_valid_b <= 1'b0;
    end else if (w_idle && rd_en_b) begin
      r_rd_data_b  <= w_rd_val_b;
      r_rd_valid_b <= 1'b1;
    end else begin
      r_rd_valid_b <= 1'b0;
    end
  end

  assign rd_data_a  = r_rd_data_a;
  assign rd_valid_a = r_rd_valid_a;
  assign rd_data_b  = r_rd_data_b;
  assign rd_valid_b = r_rd_valid_b;
  assign busy       = (r_state == S_CLEAR);

endmodule
`default_nettype wire

// File: tb/tb_reg_bank_dp.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_reg_bank_dp                                             |
// | Description : Self-checking bench for reg_bank_dp with a read scoreboard |
// |               and a small behavioural model of the bank and sweep.       |
// | Option      : REG_BANK_BYPASS_EN selects write-first expectations.       |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_reg_bank_dp;

  localparam int         AB  = 4;
  localparam int         DB  = 8;
  localparam int         DEP = 16;
  localparam logic [7:0] CLR = 8'hA5;

  logic          clk = 1'b0;
  logic          rst;
  logic          clr;
  logic          wr_en;
  logic [AB-1:0] wr_addr;
  logic [DB-1:0] wr_data;
  logic [DB-1:0] wr_mask;
  logic          rd_en_a;
  logic [AB-1:0] rd_addr_a;
  logic [DB-1:0] rd_data_a;
  logic          rd_valid_a;
  logic          rd_en_b;
  logic [AB-1:0] rd_addr_b;
  logic [DB-1:0] rd_data_b;
  logic          rd_valid_b;
  logic          busy;

  int n_total = 0;
  int n_bad   = 0;

  // Behavioural model and read scoreboards
  logic [7:0] m_bank [DEP];
  int         m_left = 0;
  int         m_ptr  = 0;
  logic [7:0] q_a [$];
  logic [7:0] q_b [$];

  always #5 clk = ~clk;

  reg_bank_dp #(
    .ADDR_BITS (AB),
    .DATA_BITS (DB),
    .CLR_VALUE (CLR)
  ) u_dut (
    .clk        (clk),
    .rst        (rst),
    .clr        (clr),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .wr_mask    (wr_mask),
    .rd_en_a    (rd_en_a),
    .rd_addr_a  (rd_addr_a),
    .rd_data_a  (rd_data_a),
    .rd_valid_a (rd_valid_a),
    .rd_en_b    (rd_en_b),
    .rd_addr_b  (rd_addr_b),
    .rd_data_b  (rd_data_b),
    .rd_valid_b (rd_valid_b),
    .busy       (busy)
  );

  function automatic logic [7:0] rd_model(input logic [3:0] addr);
    logic [7:0] v;
    v = m_bank[addr];
`ifdef REG_BANK_BYPASS_EN
    if (wr_en && !clr && addr == wr_addr)
      v = (m_bank[wr_addr] & ~wr_mask) | (wr_data & wr_mask);
`endif
    return v;
  endfunction

  // Push expected read data, advance the model, then cross one clock edge.
  task automatic step();
    if (!rst && m_left == 0) begin
      if (rd_en_a) q_a.push_back(rd_model(rd_addr_a));
      if (rd_en_b) q_b.push_back(rd_model(rd_addr_b));
    end
    if (rst) begin
      m_left = DEP; m_ptr = 0;
    end else if (m_left > 0) begin
      m_bank[m_ptr] = CLR; m_ptr++; m_left--;
    end else if (clr) begin
      m_left = DEP; m_ptr = 0;
    end else if (wr_en) begin
      m_bank[wr_addr] = (m_bank[wr_addr] & ~wr_mask) | (wr_data & wr_mask);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    rst = 1'b0; clr = 1'b0; wr_en = 1'b0; rd_en_a = 1'b0; rd_en_b = 1'b0;
  endtask

  task automatic wr(input logic [3:0] a, input logic [7:0] d, input logic [7:0] m);
    wr_en = 1'b1; wr_addr = a; wr_data = d; wr_mask = m;
    step();
    wr_en = 1'b0;
  endtask

  task automatic test_reset();
    quiet(); wr_addr = '0; wr_data = '0; wr_mask = '0; rd_addr_a = '0; rd_addr_b = '0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_total++; if (busy !== 1'b1) begin n_bad++; $display("FAIL reset_busy: got %b want 1", busy); end
    n_total++; if (rd_valid_a !== 1'b0 || rd_valid_b !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got a=%b b=%b want 0 0", rd_valid_a, rd_valid_b); end
    n_total++; if (rd_data_a !== 8'h00 || rd_data_b !== 8'h00) begin n_bad++; $display("FAIL reset_data: got a=%h b=%h want 00 00", rd_data_a, rd_data_b); end
    for (int i = 0; i < DEP; i++) begin
      step();
      n_total++; if (busy !== (i < DEP - 1)) begin n_bad++; $display("FAIL reset_sweep_busy[%0d]: got %b want %b", i, busy, (i < DEP - 1)); end
    end
    rd_en_a = 1'b1; rd_addr_a = 4'd0; rd_en_b = 1'b1; rd_addr_b = 4'd15;
    step();
    quiet();
    n_total++; if (rd_valid_a !== 1'b1 || rd_data_a !== q_a.pop_front()) begin n_bad++; $display("FAIL reset_read_a0: got v=%b d=%h want v=1 d=%h", rd_valid_a, rd_data_a, CLR); end
    n_total++; if (rd_valid_b !== 1'b1 || rd_data_b !== q_b.pop_front()) begin n_bad++; $display("FAIL reset_read_b15: got v=%b d=%h want v=1 d=%h", rd_valid_b, rd_data_b, CLR); end
    step();
    n_total++; if (rd_valid_a !== 1'b0 || rd_valid_b !== 1'b0) begin n_bad++; $display("FAIL reset_valid_pulse: got a=%b b=%b want 0 0", rd_valid_a, rd_valid_b); end
  endtask

  task automatic test_masked_write();
    logic [7:0] e;
    wr(4'd3, 8'h00, 8'hFF);
    wr(4'd3, 8'hFF, 8'h0F);
    rd_en_a = 1'b1; rd_addr_a = 4'd3;
    step(); quiet();
    e = q_a.pop_front();
    n_total++; if (rd_valid_a !== 1'b1 || rd_data_a !== e || e !== 8'h0F) begin n_bad++; $display("FAIL mask_low: got v=%b d=%h want v=1 d=0f", rd_valid_a, rd_data_a); end
    wr(4'd3, 8'h30, 8'hF0);
    rd_en_b = 1'b1; rd_addr_b = 4'd3;
    step(); quiet();
    e = q_b.pop_front();
    n_total++; if (rd_valid_b !== 1'b1 || rd_data_b !== e || e !== 8'h3F) begin n_bad++; $display("FAIL mask_high: got v=%b d=%h want v=1 d=3f", rd_valid_b, rd_data_b); end
    wr(4'd3, 8'hAA, 8'h00);
    rd_en_a = 1'b1; rd_addr_a = 4'd3;
    step(); quiet();
    e = q_a.pop_front();
    n_total++; if (rd_data_a !== e || e !== 8'h3F) begin n_bad++; $display("FAIL mask_zero: got %h want 3f", rd_data_a); end
  endtask

  task automatic test_dual_read();
    wr(4'd2, 8'h11, 8'hFF);
    wr(4'd7, 8'h77, 8'hFF);
    rd_en_a = 1'b1; rd_addr_a = 4'd2; rd_en_b = 1'b1; rd_addr_b = 4'd7;
    step(); quiet();
    n_total++; if (rd_valid_a !== 1'b1 || rd_data_a !== q_a.pop_front()) begin n_bad++; $display("FAIL dual_a: got v=%b d=%h want v=1 d=11", rd_valid_a, rd_data_a); end
    n_total++; if (rd_valid_b !== 1'b1 || rd_data_b !== q_b.pop_front()) begin n_bad++; $display("FAIL dual_b: got v=%b d=%h want v=1 d=77", rd_valid_b, rd_data_b); end
    step();
    n_total++; if (rd_valid_a !== 1'b0 || rd_valid_b !== 1'b0) begin n_bad++; $display("FAIL dual_pulse: got a=%b b=%b want 0 0", rd_valid_a, rd_valid_b); end
    n_total++; if (rd_data_a !== 8'h11 || rd_data_b !== 8'h77) begin n_bad++; $display("FAIL dual_hold: got a=%h b=%h want 11 77", rd_data_a, rd_data_b); end
  endtask

  task automatic test_collision();
    logic [7:0] e;
    wr(4'd5, 8'h12, 8'hFF);
    wr_en = 1'b1; wr_addr = 4'd5; wr_data = 8'hFF; wr_mask = 8'hFF;
    rd_en_a = 1'b1; rd_addr_a = 4'd5;
    step(); quiet();
    e = q_a.pop_front();
`ifdef REG_BANK_BYPASS_EN
    n_total++; if (rd_valid_a !== 1'b1 || rd_data_a !== e || e !== 8'hFF) begin n_bad++; $display("FAIL collide: got v=%b d=%h want v=1 d=ff", rd_valid_a, rd_data_a); end
`else
    n_total++; if (rd_valid_a !== 1'b1 || rd_data_a !== e || e !== 8'h12) begin n_bad++; $display("FAIL collide: got v=%b d=%h want v=1 d=12", rd_valid_a, rd_data_a); end
`endif
    rd_en_a = 1'b1; rd_addr_a = 4'd5; rd_en_b = 1'b1; rd_addr_b = 4'd5;
    step(); quiet();
    n_total++; if (rd_data_a !== q_a.pop_front() || rd_data_a !== 8'hFF) begin n_bad++; $display("FAIL collide_after_a: got %h want ff", rd_data_a); end
    n_total++; if (rd_data_b !== q_b.pop_front() || rd_data_b !== 8'hFF) begin n_bad++; $display("FAIL collide_after_b: got %h want ff", rd_data_b); end
  endtask

  task automatic test_clear_priority();
    wr(4'd9, 8'h55, 8'hFF);
    clr = 1'b1; wr_en = 1'b1; wr_addr = 4'd9; wr_data = 8'hEE; wr_mask = 8'hFF;
    rd_en_a = 1'b1; rd_addr_a = 4'd9;
    step(); quiet();
    n_total++; if (rd_valid_a !== 1'b1 || rd_data_a !== q_a.pop_front()) begin n_bad++; $display("FAIL clr_same_read: got v=%b d=%h want v=1 d=55", rd_valid_a, rd_data_a); end
    n_total++; if (busy !== 1'b1) begin n_bad++; $display("FAIL clr_busy_start: got %b want 1", busy); end
    for (int i = 0; i < DEP; i++) begin
      wr_en = 1'b1; wr_addr = 4'd9; wr_data = 8'h33; wr_mask = 8'hFF;
      rd_en_a = 1'b1; rd_addr_a = 4'(i); rd_en_b = 1'b1; rd_addr_b = 4'd9;
      clr = (i == 3);
      step();
      n_total++; if (rd_valid_a !== 1'b0 || rd_valid_b !== 1'b0) begin n_bad++; $display("FAIL clr_busy_read[%0d]: got a=%b b=%b want 0 0", i, rd_valid_a, rd_valid_b); end
      n_total++; if (busy !== (i < DEP - 1)) begin n_bad++; $display("FAIL clr_busy[%0d]: got %b want %b", i, busy, (i < DEP - 1)); end
    end
    quiet();
    rd_en_a = 1'b1; rd_addr_a = 4'd9;
    step(); quiet();
    n_total++; if (rd_valid_a !== 1'b1 || rd_data_a !== q_a.pop_front()) begin n_bad++; $display("FAIL clr_result: got v=%b d=%h want v=1 d=%h", rd_valid_a, rd_data_a, CLR); end
  endtask

  task automatic test_reset_mid_sweep();
    for (int i = 0; i < DEP; i++) wr(4'(i), 8'(i * 13 + 7), 8'hFF);
    clr = 1'b1;
    step(); quiet();
    for (int i = 0; i < 8; i++) step();
    n_total++; if (busy !== 1'b1) begin n_bad++; $display("FAIL mid_busy: got %b want 1", busy); end
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < DEP; i++) begin
      step();
      n_total++; if (busy !== (i < DEP - 1)) begin n_bad++; $display("FAIL mid_restart_busy[%0d]: got %b want %b", i, busy, (i < DEP - 1)); end
    end
    for (int i = 0; i < DEP; i++) begin
      rd_en_a = 1'b1; rd_addr_a = 4'(i); rd_en_b = 1'b1; rd_addr_b = 4'(DEP - 1 - i);
      step(); quiet();
      n_total++; if (rd_valid_a !== 1'b1 || rd_data_a !== q_a.pop_front()) begin n_bad++; $display("FAIL mid_entry_a[%0d]: got v=%b d=%h want v=1 d=%h", i, rd_valid_a, rd_data_a, CLR); end
      n_total++; if (rd_valid_b !== 1'b1 || rd_data_b !== q_b.pop_front()) begin n_bad++; $display("FAIL mid_entry_b[%0d]: got v=%b d=%h want v=1 d=%h", DEP - 1 - i, rd_valid_b, rd_data_b, CLR); end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_masked_write();
    test_dual_read();
    test_collision();
    test_clear_priority();
    test_reset_mid_sweep();
    n_total++; if (q_a.size() != 0 || q_b.size() != 0) begin n_bad++; $display("FAIL scoreboard_drain: got a=%0d b=%0d want 0 0", q_a.size(), q_b.size()); end
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
